video_scan_ctrl: RTL
====================

# video_scan_ctrl

Raster scan sequencer for the video sync path. It owns the horizontal pixel counter and the vertical line counter, and decodes them into the horizontal/vertical sync, composite sync and blanking strobes that downstream sync/blank logic consumes. A run/stop handshake starts and stops scanning only on frame boundaries, so a stop request never emits a truncated frame.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level request to scan (1) or stop at the end of the frame (0)
- pix_en  in  1  pixel-rate enable; counters advance only when it is 1
- hcnt  out  CW  current pixel index, 0..H_TOTAL-1
- vcnt  out  CW  current line index, 0..V_TOTAL-1
- hsync  out  1  active-high horizontal sync
- vsync  out  1  active-high vertical sync
- csync  out  1  active-high composite sync
- cblank  out  1  active-high blanking
- line_start  out  1  one-cycle pulse at pixel 0 of each line
- frame_start  out  1  one-cycle pulse at pixel 0 of line 0
- busy  out  1  1 whenever the state is not IDLE

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way from the V_ parameters.
- States and transitions:
  - IDLE: counters held at 0. If run=1, go to RUN on the next clock.
  - RUN: if run=0, go to STOP on the next clock.
  - STOP: keep scanning. If run=1, return to RUN with no counter disturbance. When the last pixel of the frame is consumed (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, pix_en=1), go to IDLE, and counters load 0.
- Counters, in RUN and STOP when pix_en=1:
  - hcnt increments.
  - At H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - At V_TOTAL-1 with a line wrap, vcnt wraps to 0.
  - Counters never exceed TOTAL-1 and use unsigned arithmetic modulo the wrap point.
- Output decodes, from the current registered counters while not IDLE:
  - hsync = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vsync = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - cblank = (hcnt >= H_ACTIVE) or (vcnt >= V_ACTIVE)
  - line_start = pix_en and hcnt=0
  - frame_start = line_start and vcnt=0
- In IDLE: hsync=vsync=csync=0, cblank=1, line_start=frame_start=0.
- Simultaneous events:
  - run dropping on the final pixel of a frame still passes through STOP and then runs one more full frame.
  - rst dominates run and pix_en.

## Timing
- Reset values: state IDLE, hcnt=vcnt=0, hsync=vsync=csync=0, cblank=1, line_start=frame_start=0, busy=0.
- Reset mid-frame aborts immediately: outputs take reset values on the cycle after rst is sampled.
- run=1 sampled in IDLE at edge N:
  - busy=1 and counters read (0,0) from edge N.
  - frame_start is 1 in the first cycle with pix_en=1.
- Counters advance on the edge that samples pix_en=1. Decoded outputs change in the same cycle as the counters, with zero added latency.
- pix_en=0 holds all counters and level outputs. line_start and frame_start are 0 while pix_en=0.

## Configuration
- VIDEO_SCAN_SERRATE_EN defined: csync = hsync XOR vsync, giving serrated vertical sync (inverted hsync pulses during vsync lines).
- VIDEO_SCAN_SERRATE_EN undefined: csync = hsync OR vsync.

## Test plan
Benches use H=4/1/2/1 (H_TOTAL=8) and V=3/1/1/1 (V_TOTAL=6), CW=4, pix_en=1, unless a scenario says otherwise.
- Reset then run=1 -> busy=1 after 1 clock, frame_start pulses at (0,0), and every 8 cycles line_start pulses with vcnt incrementing 0..5 and wrapping.
- One line at vcnt=0 -> cblank=1 at hcnt=4..7, hsync=1 at hcnt=5..6, vsync=0. At vcnt=4, vsync=1 for all 8 pixels.
- csync at vcnt=4:
  - macro defined: csync=0 at hcnt 5..6 and 1 elsewhere in the line.
  - macro undefined: csync=1 for the whole line.
- Drop run at hcnt=2, vcnt=1 -> scanning continues to (7,5), then IDLE: busy=0, counters 0, cblank=1. Re-raising run during STOP keeps the scan continuous with no return to IDLE.
- Toggle pix_en 1/0 alternately -> counters advance every other cycle, the frame spans 96 cycles, and line_start is never high while pix_en=0.
- Assert rst at (3,2) -> all outputs take reset values next cycle and remain there until run is sampled after rst is released.

Source files
------------

// File: rtl/video_scan_ctrl.sv
// Raster scan sequencer: pixel/line counters, sync/blank decode, frame-aligned run/stop.
// Define VIDEO_SCAN_SERRATE_EN for serrated composite sync (hsync XOR vsync).
module video_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          pix_en,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          cblank,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Decode bounds carry one extra bit so a sync end equal to TOTAL still fits.
  localparam logic [CW:0] H_ACT  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          h_last, v_last, advance;
  logic [CW:0]   hx, vx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    h_last  = (hcnt_q == H_LAST);
    v_last  = (vcnt_q == V_LAST);
    advance = (state_q != ST_IDLE) && pix_en;

    if (advance) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + CW'(1);
      end else begin
        hcnt_d = hcnt_q + CW'(1);
      end
    end

    // Leaving STOP on the last pixel coincides with the natural wrap to (0,0).
    unique case (state_q)
      ST_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (run) state_d = ST_RUN;
        else if (advance && h_last && v_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hx          = {1'b0, hcnt_q};
    vx          = {1'b0, vcnt_q};
    busy        = (state_q != ST_IDLE);
    hsync       = busy && (hx >= HS_BEG) && (hx < HS_END);
    vsync       = busy && (vx >= VS_BEG) && (vx < VS_END);
    cblank      = !busy || (hx >= H_ACT) || (vx >= V_ACT);
    line_start  = busy && pix_en && (hcnt_q == '0);
    frame_start = line_start && (vcnt_q == '0);
`ifdef VIDEO_SCAN_SERRATE_EN
    csync       = hsync ^ vsync;
`else
    csync       = hsync | vsync;
`endif
  end

  assign hcnt = hcnt_q;
  assign vcnt = vcnt_q;

endmodule
